// File: rtl/if_id_fetch_if.sv
// Fetch-stage bus: hazard/branch controls and loader write port in,
// fetch PC and IF/ID register contents out.
interface if_id_fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [63:0] pc_out;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  modport master (
    output stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
    input  pc_out, if_id_pc, if_id_instr, if_id_valid, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
    output pc_out, if_id_pc, if_id_instr, if_id_valid, fetch_count
  );
endinterface

// File: rtl/if_id_fetch.sv
// RV64 instruction fetch with internal word-addressed instruction memory
// and IF/ID pipeline register; supports stall, branch redirect/flush and a loader port.
module if_id_fetch #(
  parameter logic [63:0] PC_RESET   = 64'h0,
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input logic           clk,
  input logic           reset,
  if_id_fetch_if.slave  bus
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] mem_q [IMEM_DEPTH];

  logic [63:0] pc_q, pc_d;
  logic [63:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [AW-1:0] rd_idx_s;
  logic [AW-1:0] wr_idx_s;
  logic [31:0]   rd_data_s;

  // Address bits outside the word index are intentionally ignored (wrap / alignment).
  logic unused_addr_s;
  assign unused_addr_s = ^{bus.imem_waddr[63:AW+2], bus.imem_waddr[1:0],
                           bus.branch_target[1:0]};

  assign rd_idx_s  = pc_q[AW+1:2];
  assign wr_idx_s  = bus.imem_waddr[AW+1:2];
  assign rd_data_s = mem_q[rd_idx_s];

  // Loader write port; the read above sees the pre-edge word on a collision.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      mem_q[wr_idx_s] <= bus.imem_wdata;
    end
  end

  // Next-state selection: branch flush > stall hold > sequential fetch.
  always_comb begin
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    if (bus.branch_taken) begin
      pc_d          = {bus.branch_target[63:2], 2'b00};
      if_id_pc_d    = 64'h0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (bus.stall) begin
      pc_d          = pc_q;
    end else begin
      pc_d          = pc_q + 64'd4;
      if_id_pc_d    = pc_q;
      if_id_instr_d = rd_data_s;
      if_id_valid_d = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // PC and IF/ID register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= PC_RESET;
      if_id_pc_q    <= 64'h0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_id_fetch.sv
// Directed, table-driven bench for if_id_fetch with hand-written corner sequences.
module tb_if_id_fetch;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] WA  = 32'hAAAA0005;
  localparam logic [31:0] WB  = 32'hBBBB0005;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  if_id_fetch_if bus ();

  if_id_fetch #(
    .PC_RESET  (64'h0),
    .IMEM_DEPTH(256),
    .NOP_INSTR (32'h00000013)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [63:0] target;
    logic [63:0] exp_pc;
    logic [63:0] exp_ifpc;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] pc, input logic [63:0] ifpc,
                         input logic [31:0] instr, input logic valid, input logic [31:0] cnt);
    chk({tag, ".pc_out"},      bus.pc_out,              pc);
    chk({tag, ".if_id_pc"},    bus.if_id_pc,            ifpc);
    chk({tag, ".if_id_instr"}, {32'h0, bus.if_id_instr}, {32'h0, instr});
    chk({tag, ".if_id_valid"}, {63'h0, bus.if_id_valid}, {63'h0, valid});
    chk({tag, ".fetch_count"}, {32'h0, bus.fetch_count}, {32'h0, cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic br, input logic [63:0] tgt);
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = 64'(idx) << 2;
    bus.imem_wdata = data;
    tick();
    bus.imem_we    = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 64'h0,   64'h4,   64'h0,   32'h00500093, 1'b1, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 64'h0,   64'h8,   64'h4,   32'h00A00113, 1'b1, 32'd2};
    vecs[2]  = '{1'b1, 1'b0, 64'h0,   64'h8,   64'h4,   32'h00A00113, 1'b1, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 64'h0,   64'h8,   64'h4,   32'h00A00113, 1'b1, 32'd2};
    vecs[4]  = '{1'b1, 1'b0, 64'h0,   64'h8,   64'h4,   32'h00A00113, 1'b1, 32'd2};
    vecs[5]  = '{1'b0, 1'b0, 64'h0,   64'hC,   64'h8,   32'h002081B3, 1'b1, 32'd3};
    vecs[6]  = '{1'b1, 1'b1, 64'h40,  64'h40,  64'h0,   NOP,          1'b0, 32'd3};
    vecs[7]  = '{1'b0, 1'b0, 64'h0,   64'h44,  64'h40,  32'hDEAD0040, 1'b1, 32'd4};
    vecs[8]  = '{1'b0, 1'b1, 64'h43,  64'h40,  64'h0,   NOP,          1'b0, 32'd4};
    vecs[9]  = '{1'b0, 1'b0, 64'h0,   64'h44,  64'h40,  32'hDEAD0040, 1'b1, 32'd5};
    vecs[10] = '{1'b0, 1'b1, 64'h400, 64'h400, 64'h0,   NOP,          1'b0, 32'd5};
    vecs[11] = '{1'b0, 1'b0, 64'h0,   64'h404, 64'h400, 32'h00500093, 1'b1, 32'd6};
    vecs[12] = '{1'b0, 1'b0, 64'h0,   64'h408, 64'h404, 32'h00A00113, 1'b1, 32'd7};

    reset = 1'b1;
    drive(1'b0, 1'b0, 64'h0);
    bus.imem_we    = 1'b0;
    bus.imem_waddr = 64'h0;
    bus.imem_wdata = 32'h0;

    // Program load happens while reset is held: memory writes ignore reset.
    load_word(0,  32'h00500093);
    load_word(1,  32'h00A00113);
    load_word(2,  32'h002081B3);
    load_word(3,  32'h00000013);
    load_word(4,  32'h11111111);
    load_word(5,  WA);
    load_word(6,  32'h66666666);
    load_word(16, 32'hDEAD0040);
    load_word(17, 32'h17171717);
    tick();
    chk_all("reset", 64'h0, 64'h0, NOP, 1'b0, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].target);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_ifpc,
              vecs[i].exp_instr, vecs[i].exp_valid, vecs[i].exp_cnt);
    end

    // Write/fetch collision at index 5: fetch sees the old word.
    drive(1'b0, 1'b1, 64'h14);
    tick();
    chk_all("coll_br", 64'h14, 64'h0, NOP, 1'b0, 32'd7);
    drive(1'b0, 1'b0, 64'h0);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = 64'h14;
    bus.imem_wdata = WB;
    tick();
    bus.imem_we    = 1'b0;
    chk_all("coll_old", 64'h18, 64'h14, WA, 1'b1, 32'd8);
    drive(1'b0, 1'b1, 64'h14);
    tick();
    chk_all("coll_rebr", 64'h14, 64'h0, NOP, 1'b0, 32'd8);
    drive(1'b0, 1'b0, 64'h0);
    tick();
    chk_all("coll_new", 64'h18, 64'h14, WB, 1'b1, 32'd9);

    // Reset dominates stall and branch mid-stream.
    reset = 1'b1;
    drive(1'b1, 1'b1, 64'h80);
    tick();
    chk_all("mid_reset", 64'h0, 64'h0, NOP, 1'b0, 32'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 64'h0);
    tick();
    chk_all("post_reset", 64'h4, 64'h0, 32'h00500093, 1'b1, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
